dca_matrix_stream_register: RTL and testbench

Square N×N scalar matrix register with a valid/ready row-stream port in each direction, a row-occupancy counter, and a single-cycle full-matrix transpose. Rows stream in at the bottom of the occupied region and drain from the top, LANES rows per beat. It replaces the fixed one-row move port used in DCA datapaths. It sits between DCA tensor DMA/stream logic and the compute array, which keeps direct element-parallel access.

---
 rtl/dca_matrix_stream_register_pkg.sv | 38 +++
 rtl/dca_matrix_stream_register_if.sv | 12 +
 rtl/dca_stream_count_ctrl.sv | 85 ++++++++
 rtl/dca_matrix_stream_register.sv | 116 +++++++++++
 tb/tb_dca_matrix_stream_register.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dca_matrix_stream_register_pkg.sv
// Shared constants and helpers for the DCA matrix stream register.
// Defaults describe the standard DCA configuration; the top module
// carries the actual parameters and derives its widths from these helpers.
package dca_matrix_stream_pkg;

  localparam int DEF_MATRIX_SIZE = 8;
  localparam int DEF_LANES       = 1;
  localparam int DEF_BW_SCALAR   = 32;

  // Stream operation seen by the row counter in one cycle: {load_fire, store_fire}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOAD  = 2'b10,
    OP_PASS  = 2'b11
  } stream_op_e;

  // Width of one stream beat: LANES rows of N scalars.
  function automatic int beat_width(input int n, input int lanes, input int bw);
    return lanes * n * bw;
  endfunction

  // Width of the occupied-row counter, which must hold 0..N inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Number of beats needed to fill the whole matrix.
  function automatic int beats_per_matrix(input int n, input int lanes);
    return n / lanes;
  endfunction

  // Flat index of element (r,c) in the list2d buses.
  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/dca_matrix_stream_register_if.sv
// Valid/ready row-stream channel carrying LANES rows per beat.
// The producer uses the master modport, the consumer the slave modport.
interface dca_matrix_stream_register_if #(
  parameter int BW_BEAT = 256
);
  logic               valid;
  logic               ready;
  logic [BW_BEAT-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dca_stream_count_ctrl.sv
// Row-occupancy counter and stream handshake control.
// Produces the load/store fire strobes, the transpose qualifier and the
// row index at which an incoming beat is written.
module dca_stream_count_ctrl
  import dca_matrix_stream_pkg::*;
#(
  parameter  int MATRIX_SIZE_PARA = DEF_MATRIX_SIZE,
  parameter  int LANES            = DEF_LANES,
  localparam int BW_COUNT         = count_width(MATRIX_SIZE_PARA)
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                i_init,
  input  logic                i_transpose,
  input  logic                i_load_valid,
  input  logic                i_store_ready,
  output logic                o_load_ready,
  output logic                o_store_valid,
  output logic                o_load_fire,
  output logic                o_store_fire,
  output logic                o_xpose_act,
  output logic [BW_COUNT-1:0] o_wr_base,
  output logic [BW_COUNT-1:0] o_count,
  output logic                o_full
);

  localparam logic [BW_COUNT-1:0] C_N     = BW_COUNT'(MATRIX_SIZE_PARA);
  localparam logic [BW_COUNT-1:0] C_LANES = BW_COUNT'(LANES);
  localparam logic [BW_COUNT-1:0] C_ROOM  = BW_COUNT'(MATRIX_SIZE_PARA - LANES);

  logic [BW_COUNT-1:0] r_count;
  logic                w_full;
  logic                w_has_beat;
  logic                w_has_room;
  logic                w_xpose_act;
  logic                w_load_ready;
  logic                w_store_valid;
  logic                w_load_fire;
  logic                w_store_fire;
  stream_op_e          w_op;

  assign w_full     = (r_count == C_N);
  assign w_has_beat = (r_count >= C_LANES);
  assign w_has_room = (r_count <= C_ROOM);

  // Transpose only when the matrix is full and the stream is quiet; init wins.
  assign w_xpose_act = i_transpose & w_full & ~i_load_valid & ~i_store_ready & ~i_init;

  // An active transpose implies full and ~store_ready, where load_ready is
  // already 0, so it is left out here to keep load_ready free of load_valid.
  assign w_load_ready  = (w_has_room | (i_store_ready & w_has_beat)) & ~i_init;
  assign w_store_valid = w_has_beat & ~w_xpose_act & ~i_init;

  assign w_load_fire  = i_load_valid & w_load_ready;
  assign w_store_fire = w_store_valid & i_store_ready;
  assign w_op         = stream_op_e'({w_load_fire, w_store_fire});

  // With a store in the same cycle the rows move up first, so the beat lands one beat higher.
  assign o_wr_base = w_store_fire ? (r_count - C_LANES) : r_count;

  // Occupancy counter: +LANES per load beat, -LANES per store beat.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_count <= '0;
    end else if (i_init) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_LOAD:  r_count <= r_count + C_LANES;
        OP_STORE: r_count <= r_count - C_LANES;
        default:  r_count <= r_count;
      endcase
    end
  end

  assign o_load_ready  = w_load_ready;
  assign o_store_valid = w_store_valid;
  assign o_load_fire   = w_load_fire;
  assign o_store_fire  = w_store_fire;
  assign o_xpose_act   = w_xpose_act;
  assign o_count       = r_count;
  assign o_full        = w_full;

endmodule

// File: rtl/dca_matrix_stream_register.sv
// N x N scalar matrix register with row-stream load/store ports,
// single-cycle transpose and per-element direct writes.
// Rows enter below the occupied region and drain from row 0.
module dca_matrix_stream_register
  import dca_matrix_stream_pkg::*;
#(
  parameter  int                          MATRIX_SIZE_PARA = DEF_MATRIX_SIZE,
  parameter  int                          BW_TENSOR_SCALAR = DEF_BW_SCALAR,
  parameter  int                          LANES            = DEF_LANES,
  parameter  logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE      = '0,
  parameter  logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE       = RESET_VALUE,
  localparam int                          N                = MATRIX_SIZE_PARA,
  localparam int                          BW               = BW_TENSOR_SCALAR,
  localparam int                          BW_COUNT         = count_width(MATRIX_SIZE_PARA)
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          init,
  dca_matrix_stream_register_if.slave   load_port,
  dca_matrix_stream_register_if.master  store_port,
  input  logic                          transpose,
  input  logic [N*N-1:0]                all_wenable_list2d,
  input  logic [N*N*BW-1:0]             all_wdata_list2d,
  output logic [N*N*BW-1:0]             all_rdata_list2d,
  output logic [BW_COUNT-1:0]           count,
  output logic                          full
);

  localparam int ROW_W   = N * BW;
  localparam int BW_BEAT = beat_width(N, LANES, BW);

  if (beats_per_matrix(N, LANES) * LANES != N) begin : g_bad_lanes
    $error("LANES must divide MATRIX_SIZE_PARA");
  end

  logic                w_load_ready;
  logic                w_store_valid;
  logic                w_load_fire;
  logic                w_store_fire;
  logic                w_xpose_act;
  logic [BW_COUNT-1:0] w_wr_base;
  logic [N*N*BW-1:0]   w_rdata;

  dca_stream_count_ctrl #(
    .MATRIX_SIZE_PARA (N),
    .LANES            (LANES)
  ) u_count_ctrl (
    .clk           (clk),
    .rstnn         (rstnn),
    .i_init        (init),
    .i_transpose   (transpose),
    .i_load_valid  (load_port.valid),
    .i_store_ready (store_port.ready),
    .o_load_ready  (w_load_ready),
    .o_store_valid (w_store_valid),
    .o_load_fire   (w_load_fire),
    .o_store_fire  (w_store_fire),
    .o_xpose_act   (w_xpose_act),
    .o_wr_base     (w_wr_base),
    .o_count       (count),
    .o_full        (full)
  );

  for (genvar r = 0; r < N; r++) begin : g_row
    // Beats are LANES-aligned, so a row only ever takes lane (r % LANES) of a beat.
    localparam int                  LANE = r % LANES;
    localparam logic [BW_COUNT-1:0] BASE = BW_COUNT'(r - LANE);

    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_shift_row;
    logic [ROW_W-1:0] w_load_row;
    logic             w_shift_hit;
    logic             w_load_hit;

    if (r + LANES < N) begin : g_shift
      assign w_shift_row = w_rdata[(r+LANES)*ROW_W +: ROW_W];
      assign w_shift_hit = w_store_fire;
    end else begin : g_vacate
      // Bottom rows vacated by a store keep their stale contents.
      assign w_shift_row = r_row;
      assign w_shift_hit = 1'b0;
    end

    assign w_load_row = load_port.data[LANE*ROW_W +: ROW_W];
    assign w_load_hit = w_load_fire & (w_wr_base == BASE);
    assign w_rdata[r*ROW_W +: ROW_W] = r_row;

    // Row update: init, then transpose, then stream, with direct writes filling in untouched elements.
    // NOTE: these are discrete flops rather than a RAM, so every element is async-reset.
    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        r_row <= {N{RESET_VALUE}};
      end else if (init) begin
        r_row <= {N{INIT_VALUE}};
      end else if (w_xpose_act) begin
        for (int c = 0; c < N; c++) begin
          r_row[c*BW +: BW] <= w_rdata[elem_idx(c, r, N)*BW +: BW];
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          if (all_wenable_list2d[elem_idx(r, c, N)]) begin
            r_row[c*BW +: BW] <= all_wdata_list2d[elem_idx(r, c, N)*BW +: BW];
          end
        end
        if (w_shift_hit) r_row <= w_shift_row;
        if (w_load_hit)  r_row <= w_load_row;
      end
    end
  end

  assign load_port.ready  = w_load_ready;
  assign store_port.valid = w_store_valid;
  assign store_port.data  = w_rdata[BW_BEAT-1:0];
  assign all_rdata_list2d = w_rdata;

endmodule

// File: tb/tb_dca_matrix_stream_register.sv
// Directed bench for the matrix stream register: N=4, LANES=2, BW=8.
// Element (r,c) sits at byte r*4+c of the 128-bit list2d buses.
module tb_dca_matrix_stream_register;
  import dca_matrix_stream_pkg::*;

  localparam int N        = 4;
  localparam int LANES    = 2;
  localparam int BW       = 8;
  localparam int BW_BEAT  = 64;
  localparam int BW_COUNT = 3;

  logic                clk = 1'b0;
  logic                rstnn;
  logic                init;
  logic                transpose;
  logic [N*N-1:0]      wen;
  logic [N*N*BW-1:0]   wdata;
  logic [N*N*BW-1:0]   rdata;
  logic [BW_COUNT-1:0] count;
  logic                full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dca_matrix_stream_register_if #(.BW_BEAT(BW_BEAT)) load_if ();
  dca_matrix_stream_register_if #(.BW_BEAT(BW_BEAT)) store_if ();

  dca_matrix_stream_register #(
    .MATRIX_SIZE_PARA (N),
    .BW_TENSOR_SCALAR (BW),
    .LANES            (LANES),
    .RESET_VALUE      (8'h00),
    .INIT_VALUE       (8'h5C)
  ) dut (
    .clk                (clk),
    .rstnn              (rstnn),
    .init               (init),
    .load_port          (load_if),
    .store_port         (store_if),
    .transpose          (transpose),
    .all_wenable_list2d (wen),
    .all_wdata_list2d   (wdata),
    .all_rdata_list2d   (rdata),
    .count              (count),
    .full               (full)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstnn = 1'b0; init = 1'b0; transpose = 1'b0; wen = '0; wdata = '0;
    load_if.valid = 1'b0; load_if.data = '0; store_if.ready = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_store_valid", store_if.valid, 0);
    check("rst_load_ready", load_if.ready, 1);
    check("rst_rdata", rdata, 0);
    rstnn = 1'b1;
    #1;

    // Beat A (rows 0..1 = 0x00..0x07), then beat B (0x08..0x0F).
    load_if.valid = 1'b1; load_if.data = 64'h07060504_03020100;
    #1;
    check("a_load_ready", load_if.ready, 1);
    step();
    check("a_count", count, 2);
    check("a_store_valid", store_if.valid, 1);
    check("a_store_data", store_if.data, 64'h07060504_03020100);
    load_if.data = 64'h0F0E0D0C_0B0A0908;
    #1;
    check("b_load_ready", load_if.ready, 1);
    step();
    load_if.valid = 1'b0;
    #1;
    check("b_full", full, 1);
    check("b_count", count, 4);
    check("b_load_ready_blocked", load_if.ready, 0);
    check("b_store_data", store_if.data, 64'h07060504_03020100);
    check("b_rdata", rdata, 128'h0F0E0D0C0B0A0908_0706050403020100);

    // Pass-through at full: load C while storing A.
    load_if.valid = 1'b1; load_if.data = 64'h17161514_13121110; store_if.ready = 1'b1;
    #1;
    check("c_load_ready", load_if.ready, 1);
    check("c_store_valid", store_if.valid, 1);
    check("c_store_data_a", store_if.data, 64'h07060504_03020100);
    step();
    load_if.valid = 1'b0; store_if.ready = 1'b0;
    #1;
    check("c_store_data_b", store_if.data, 64'h0F0E0D0C_0B0A0908);
    check("c_count", count, 4);
    check("c_rdata", rdata, 128'h1716151413121110_0F0E0D0C0B0A0908);

    // Transpose when full: new (r,c) = old (c,r).
    transpose = 1'b1;
    #1;
    check("xp_store_valid", store_if.valid, 0);
    check("xp_load_ready", load_if.ready, 0);
    step();
    transpose = 1'b0;
    #1;
    check("xp_count", count, 4);
    check("xp_e13", rdata[(1*4+3)*8 +: 8], 8'h15);
    check("xp_rdata", rdata, 128'h17130F0B_16120E0A_15110D09_14100C08);

    // Drain one beat, then a transpose at count=2 must be ignored.
    store_if.ready = 1'b1;
    #1;
    check("drain_store_data", store_if.data, 64'h15110D09_14100C08);
    step();
    store_if.ready = 1'b0;
    #1;
    check("drain_count", count, 2);
    check("drain_rdata", rdata, 128'h17130F0B_16120E0A_17130F0B_16120E0A);
    transpose = 1'b1;
    step();
    transpose = 1'b0;
    #1;
    check("xp_half_rdata", rdata, 128'h17130F0B_16120E0A_17130F0B_16120E0A);
    check("xp_half_count", count, 2);

    // Load D into rows 2..3 with direct writes to (2,0) (collides) and (0,1) (free).
    load_if.valid = 1'b1; load_if.data = 64'h27262524_23222120;
    wen = 16'h0102;
    wdata = '0; wdata[8*8 +: 8] = 8'hAA; wdata[1*8 +: 8] = 8'hBB;
    step();
    load_if.valid = 1'b0; wen = '0;
    #1;
    check("d_e20_stream_wins", rdata[8*8 +: 8], 8'h20);
    check("d_rdata", rdata, 128'h27262524_23222120_17130F0B_1612BB0A);
    check("d_count", count, 4);

    // Direct write alone to (3,3).
    wen[15] = 1'b1; wdata[15*8 +: 8] = 8'h5A;
    step();
    wen = '0;
    #1;
    check("dw_e33", rdata[15*8 +: 8], 8'h5A);
    check("dw_rdata", rdata, 128'h5A262524_23222120_17130F0B_1612BB0A);
    check("dw_count", count, 4);

    // init with a load and store offered: both blocked, matrix cleared to INIT_VALUE.
    init = 1'b1; load_if.valid = 1'b1; load_if.data = 64'hDEADBEEF_CAFEF00D; store_if.ready = 1'b1;
    #1;
    check("init_load_ready", load_if.ready, 0);
    check("init_store_valid", store_if.valid, 0);
    step();
    init = 1'b0; load_if.valid = 1'b0; store_if.ready = 1'b0;
    #1;
    check("init_count", count, 0);
    check("init_full", full, 0);
    check("init_rdata", rdata, {16{8'h5C}});
    check("init_load_ready_after", load_if.ready, 1);

    // Pass-through at count=2: beat G lands at row 0 after F drains.
    load_if.valid = 1'b1; load_if.data = 64'h37363534_33323130;
    step();
    load_if.data = 64'h47464544_43424140; store_if.ready = 1'b1;
    #1;
    check("pt_load_ready", load_if.ready, 1);
    check("pt_store_data_f", store_if.data, 64'h37363534_33323130);
    step();
    load_if.valid = 1'b0; store_if.ready = 1'b0;
    #1;
    check("pt_store_data_g", store_if.data, 64'h47464544_43424140);
    check("pt_count", count, 2);
    check("pt_rdata", rdata, {{8{8'h5C}}, 64'h47464544_43424140});

    // Async reset mid-stream, away from the clock edge.
    load_if.valid = 1'b1; load_if.data = 64'h57565554_53525150;
    #2;
    rstnn = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_rdata", rdata, 0);
    load_if.valid = 1'b0;
    rstnn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
